speicher_arbiter: RTL and testbench

- Shares one single-port memory between the control unit's instruction fetch (LoadBefehlSignal/BefehlGeladen) and its data load/store path (LoadDatenSignal, StoreDatenSignal / DatenGeladen, DatenGespeichert).
- Sits between the control unit plus datapath and the memory.
- Uses a four-phase request/acknowledge handshake toward both requesters, round-robin arbitration and a bounded wait on the memory.

---
 rtl/speicher_pkg.sv | 26 ++
 rtl/speicher_zeitgeber.sv | 43 ++++
 rtl/speicher_arbiter.sv | 165 ++++++++++++++++
 tb/tb_speicher_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/speicher_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, grant identifiers
// and the kind of access currently in flight.
package speicher_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StZugriff  = 2'd1,
      StQuittung = 2'd2
   } state_e;

   // Which requester holds (or last held) the memory.
   typedef enum logic {
      GrantBefehl = 1'b0,
      GrantDaten  = 1'b1
   } grant_e;

   // Access kind; selects the acknowledge and the read-data destination.
   typedef enum logic [1:0] {
      OpBefehl    = 2'd0,
      OpLaden     = 2'd1,
      OpSpeichern = 2'd2
   } op_e;

   localparam int unsigned TimerWidth = 8;

endpackage

// File: rtl/speicher_zeitgeber.sv
// Timeout counter for the memory wait.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : restart counting from zero (has priority over count_i)
//   count_i       : advance by one this cycle
//   limit_i       : timeout length in cycles; zero disables the counter
//   expired_o     : counter has reached limit_i-1 (last permitted wait cycle)
module speicher_zeitgeber
   import speicher_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  count_i,
   input  logic [TimerWidth-1:0] limit_i,
   output logic                  expired_o
);

   logic [TimerWidth-1:0] cnt_q, cnt_d;
   logic                  enabled;

   assign enabled = (limit_i != '0);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (count_i && enabled) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = enabled && (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/speicher_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store.
// Four-phase request/acknowledge toward both requesters, round-robin on ties,
// bounded wait on the memory with a sticky timeout flag.
// Ports:
//   Clock, Reset                          : clock, asynchronous active-low reset
//   LoadBefehlSignal/BefehlAdresse        : fetch request and address
//   BefehlDaten/BefehlGeladen             : fetched word and fetch acknowledge
//   LoadDatenSignal/StoreDatenSignal      : data read / write requests
//   DatenAdresse/SchreibDaten             : data address and store data
//   LeseDaten/DatenGeladen/DatenGespeichert : loaded word, load ack, store ack
//   SpeicherAnfrage/SpeicherSchreiben     : memory request and write enable
//   SpeicherAdresse/SpeicherSchreibDaten  : memory address and write data
//   SpeicherLeseDaten/SpeicherBereit      : memory read data and completion
//   Zeitueberschreitung                   : sticky timeout error
module speicher_arbiter
   import speicher_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  LoadBefehlSignal,
   input  logic [ADDR_WIDTH-1:0] BefehlAdresse,
   output logic [DATA_WIDTH-1:0] BefehlDaten,
   output logic                  BefehlGeladen,
   input  logic                  LoadDatenSignal,
   input  logic                  StoreDatenSignal,
   input  logic [ADDR_WIDTH-1:0] DatenAdresse,
   input  logic [DATA_WIDTH-1:0] SchreibDaten,
   output logic [DATA_WIDTH-1:0] LeseDaten,
   output logic                  DatenGeladen,
   output logic                  DatenGespeichert,
   output logic                  SpeicherAnfrage,
   output logic                  SpeicherSchreiben,
   output logic [ADDR_WIDTH-1:0] SpeicherAdresse,
   output logic [DATA_WIDTH-1:0] SpeicherSchreibDaten,
   input  logic [DATA_WIDTH-1:0] SpeicherLeseDaten,
   input  logic                  SpeicherBereit,
   output logic                  Zeitueberschreitung
);

   localparam logic [TimerWidth-1:0] TimeoutLimit = TimerWidth'(TIMEOUT);

   state_e                state_q;
   grant_e                letzter_q;
   op_e                   op_q;
   logic [DATA_WIDTH-1:0] befehl_daten_q, lese_daten_q, schreib_daten_q;
   logic [ADDR_WIDTH-1:0] adresse_q;
   logic                  befehl_geladen_q, daten_geladen_q, daten_gespeichert_q;
   logic                  anfrage_q, schreiben_q, zeit_q;

   logic befehl_req, daten_req, pending, grant_daten, req_aktiv, abgelaufen;

   assign befehl_req = LoadBefehlSignal;
   assign daten_req  = LoadDatenSignal | StoreDatenSignal;
   assign pending    = befehl_req | daten_req;
   // Data wins when alone, or on a tie when fetch was served last.
   assign grant_daten = daten_req && (!befehl_req || (letzter_q == GrantBefehl));

   // Level of the request that owns the current acknowledge.
   always_comb begin
      req_aktiv = 1'b0;
      unique case (op_q)
         OpBefehl:    req_aktiv = LoadBefehlSignal;
         OpLaden:     req_aktiv = LoadDatenSignal;
         OpSpeichern: req_aktiv = StoreDatenSignal;
         default:     req_aktiv = 1'b0;
      endcase
   end

   speicher_zeitgeber u_zeitgeber (
      .clk_i    (Clock),
      .rst_ni   (Reset),
      .clear_i  ((state_q == StIdle) && pending),
      .count_i  ((state_q == StZugriff) && !SpeicherBereit),
      .limit_i  (TimeoutLimit),
      .expired_o(abgelaufen)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q             <= StIdle;
         letzter_q           <= GrantDaten;
         op_q                <= OpBefehl;
         befehl_daten_q      <= '0;
         lese_daten_q        <= '0;
         schreib_daten_q     <= '0;
         adresse_q           <= '0;
         befehl_geladen_q    <= 1'b0;
         daten_geladen_q     <= 1'b0;
         daten_gespeichert_q <= 1'b0;
         anfrage_q           <= 1'b0;
         schreiben_q         <= 1'b0;
         zeit_q              <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pending) begin
                  anfrage_q <= 1'b1;
                  state_q   <= StZugriff;
                  if (grant_daten) begin
                     letzter_q       <= GrantDaten;
                     adresse_q       <= DatenAdresse;
                     // Store has precedence if both data requests are high.
                     op_q            <= StoreDatenSignal ? OpSpeichern : OpLaden;
                     schreiben_q     <= StoreDatenSignal;
                     schreib_daten_q <= StoreDatenSignal ? SchreibDaten : '0;
                  end else begin
                     letzter_q       <= GrantBefehl;
                     adresse_q       <= BefehlAdresse;
                     op_q            <= OpBefehl;
                     schreiben_q     <= 1'b0;
                     schreib_daten_q <= '0;
                  end
               end
            end
            StZugriff: begin
               if (SpeicherBereit || abgelaufen) begin
                  anfrage_q <= 1'b0;
                  state_q   <= StQuittung;
                  // A timed-out read returns zero; ack anyway so nobody hangs.
                  if (!SpeicherBereit) begin
                     zeit_q <= 1'b1;
                  end
                  unique case (op_q)
                     OpBefehl: begin
                        befehl_daten_q   <= SpeicherBereit ? SpeicherLeseDaten : '0;
                        befehl_geladen_q <= 1'b1;
                     end
                     OpLaden: begin
                        lese_daten_q    <= SpeicherBereit ? SpeicherLeseDaten : '0;
                        daten_geladen_q <= 1'b1;
                     end
                     OpSpeichern: daten_gespeichert_q <= 1'b1;
                     default: ;
                  endcase
               end
            end
            StQuittung: begin
               if (!req_aktiv) begin
                  befehl_geladen_q    <= 1'b0;
                  daten_geladen_q     <= 1'b0;
                  daten_gespeichert_q <= 1'b0;
                  state_q             <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign BefehlDaten          = befehl_daten_q;
   assign BefehlGeladen        = befehl_geladen_q;
   assign LeseDaten            = lese_daten_q;
   assign DatenGeladen         = daten_geladen_q;
   assign DatenGespeichert     = daten_gespeichert_q;
   assign SpeicherAnfrage      = anfrage_q;
   assign SpeicherSchreiben    = schreiben_q;
   assign SpeicherAdresse      = adresse_q;
   assign SpeicherSchreibDaten = schreib_daten_q;
   assign Zeitueberschreitung  = zeit_q;

endmodule

// File: tb/tb_speicher_arbiter.sv
// Self-checking bench for speicher_arbiter: directed scenarios followed by
// randomized request mixes, checked against a transaction-level model.
module tb_speicher_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lbs = 1'b0, ldat = 1'b0, sdat = 1'b0, bereit = 1'b0;
   logic [31:0] badr = '0, dadr = '0, wdat = '0, rdata = '0;
   logic [31:0] befehl_daten, lese_daten, sp_adr, sp_wdat;
   logic        bg, dg, ds, sp_anf, sp_wr, zeit;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Model state: who was served last, and what each data output should hold.
   bit          last_daten = 1'b1;
   logic [31:0] exp_bd = '0, exp_ld = '0;

   speicher_arbiter #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TIMEOUT   (4)
   ) dut (
      .Clock               (clk),
      .Reset               (rst_n),
      .LoadBefehlSignal    (lbs),
      .BefehlAdresse       (badr),
      .BefehlDaten         (befehl_daten),
      .BefehlGeladen       (bg),
      .LoadDatenSignal     (ldat),
      .StoreDatenSignal    (sdat),
      .DatenAdresse        (dadr),
      .SchreibDaten        (wdat),
      .LeseDaten           (lese_daten),
      .DatenGeladen        (dg),
      .DatenGespeichert    (ds),
      .SpeicherAnfrage     (sp_anf),
      .SpeicherSchreiben   (sp_wr),
      .SpeicherAdresse     (sp_adr),
      .SpeicherSchreibDaten(sp_wdat),
      .SpeicherLeseDaten   (rdata),
      .SpeicherBereit      (bereit),
      .Zeitueberschreitung (zeit)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] ist, input logic [31:0] soll);
      n_cmp++;
      if (ist !== soll) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, ist, soll);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop(input bit port_d);
      if (port_d) begin
         ldat = 1'b0;
         sdat = 1'b0;
      end else begin
         lbs = 1'b0;
      end
   endtask

   function automatic logic [31:0] acks();
      return 32'({bg, dg, ds});
   endfunction

   // Serve one granted transaction: grant, memory waits, completion, release.
   task automatic serve(input bit port_d, input int waits, input bit withdraw);
      logic [31:0] e_addr, e_wd, rd;
      logic [2:0]  e_ack;
      bit          e_wr;
      if (port_d) begin
         e_addr = dadr;
         e_wr   = sdat;
         e_wd   = sdat ? wdat : 32'd0;
         e_ack  = sdat ? 3'b001 : 3'b010;
      end else begin
         e_addr = badr;
         e_wr   = 1'b0;
         e_wd   = 32'd0;
         e_ack  = 3'b100;
      end
      last_daten = port_d;
      tick();
      check("grant_anfrage", 32'(sp_anf), 32'd1);
      check("grant_adresse", sp_adr, e_addr);
      check("grant_schreiben", 32'(sp_wr), 32'(e_wr));
      check("grant_wdata", sp_wdat, e_wd);
      if (withdraw) drop(port_d);
      for (int i = 0; i < waits; i++) begin
         badr = $urandom;
         dadr = $urandom;
         wdat = $urandom;
         tick();
         check("warten_anfrage", 32'(sp_anf), 32'd1);
         check("warten_adresse", sp_adr, e_addr);
         check("warten_wdata", sp_wdat, e_wd);
         check("warten_ack", acks(), 32'd0);
      end
      rd     = $urandom;
      rdata  = rd;
      bereit = 1'b1;
      tick();
      bereit = 1'b0;
      rdata  = $urandom;
      if (!port_d) exp_bd = rd;
      else if (!e_wr) exp_ld = rd;
      check("fertig_ack", acks(), 32'(e_ack));
      check("fertig_anfrage", 32'(sp_anf), 32'd0);
      check("befehl_daten", befehl_daten, exp_bd);
      check("lese_daten", lese_daten, exp_ld);
      if (!withdraw) begin
         tick();
         check("ack_gehalten", acks(), 32'(e_ack));
         drop(port_d);
      end
      tick();
      check("ack_frei", acks(), 32'd0);
      check("kein_grant", 32'(sp_anf), 32'd0);
   endtask

   // Raise the given requests and serve them in round-robin order.
   task automatic transaction(input bit b, input bit l, input bit s, input int waits,
                              input bit withdraw);
      bit pend_b, pend_d, win;
      lbs    = b;
      ldat   = l;
      sdat   = s;
      pend_b = b;
      pend_d = l | s;
      while (pend_b || pend_d) begin
         win = (pend_b && pend_d) ? !last_daten : pend_d;
         serve(win, waits, withdraw);
         if (win) pend_d = 1'b0;
         else pend_b = 1'b0;
      end
   endtask

   initial begin
      #12;
      check("reset_ack", acks(), 32'd0);
      check("reset_anfrage", 32'({sp_anf, sp_wr, zeit}), 32'd0);
      check("reset_adresse", sp_adr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Fetch from 0x40 returning 0xDEADBEEF with no wait.
      badr = 32'h40;
      begin
         lbs = 1'b1;
         last_daten = 1'b0;
         tick();
         check("fetch_anfrage", 32'({sp_anf, sp_wr}), 32'b10);
         check("fetch_adresse", sp_adr, 32'h40);
         rdata  = 32'hDEADBEEF;
         bereit = 1'b1;
         tick();
         bereit = 1'b0;
         check("fetch_ack", 32'(bg), 32'd1);
         check("fetch_daten", befehl_daten, 32'hDEADBEEF);
         exp_bd = 32'hDEADBEEF;
         lbs = 1'b0;
         tick();
         check("fetch_ack_frei", 32'(bg), 32'd0);
      end

      // Store 0x12345678 to 0x80 with three wait cycles.
      dadr = 32'h80;
      wdat = 32'h12345678;
      transaction(1'b0, 1'b0, 1'b1, 3, 1'b0);

      // Two simultaneous fetch+load pairs alternate in priority.
      transaction(1'b1, 1'b1, 1'b0, 0, 1'b0);
      transaction(1'b1, 1'b1, 1'b0, 1, 1'b0);

      // Load and store both high: the store is performed.
      dadr = 32'h1C;
      wdat = 32'hA5A5_0F0F;
      transaction(1'b0, 1'b1, 1'b1, 0, 1'b0);

      // Randomized request mixes.
      for (int it = 0; it < 60; it++) begin
         bit b, l, s, wd;
         int unsigned kind;
         badr = $urandom;
         dadr = $urandom;
         wdat = $urandom;
         kind = $urandom_range(7);
         b  = 1'((kind != 1) && (kind != 2));
         l  = 1'(kind == 1 || kind == 3 || kind == 6);
         s  = 1'(kind == 2 || kind == 4 || kind == 6);
         if (!b && !l && !s) b = 1'b1;
         wd = 1'($urandom_range(3) == 0);
         transaction(b, l, s, int'($urandom_range(3)), wd);
      end

      // Memory never answers: timeout after four request cycles.
      dadr = 32'h200;
      ldat = 1'b1;
      last_daten = 1'b1;
      tick();
      check("to_anfrage", 32'(sp_anf), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("to_warten", 32'({sp_anf, zeit, dg}), 32'b100);
      end
      tick();
      exp_ld = 32'd0;
      check("to_anfrage_aus", 32'(sp_anf), 32'd0);
      check("to_flag", 32'(zeit), 32'd1);
      check("to_ack", acks(), 32'b010);
      check("to_daten", lese_daten, 32'd0);
      ldat = 1'b0;
      tick();
      check("to_ack_frei", acks(), 32'd0);
      check("to_sticky", 32'(zeit), 32'd1);
      tick();
      check("to_sticky2", 32'(zeit), 32'd1);

      // Reset during an access.
      badr = 32'h300;
      lbs  = 1'b1;
      tick();
      check("rst_grant", 32'(sp_anf), 32'd1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_ack", acks(), 32'd0);
      check("rst_ctrl", 32'({sp_anf, sp_wr, zeit}), 32'd0);
      check("rst_adresse", sp_adr, 32'd0);
      check("rst_bd", befehl_daten, 32'd0);
      check("rst_ld", lese_daten, 32'd0);
      lbs = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      last_daten = 1'b1;
      exp_bd = 32'd0;
      exp_ld = 32'd0;
      badr = 32'h44;
      transaction(1'b1, 1'b0, 1'b0, 1, 1'b0);
      check("rst_zeit_bleibt_aus", 32'(zeit), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
